// File: rtl/frame_pkg.sv
// Frame geometry and control-state encodings shared by the frame DRAM
// reader, writer and filter blocks.
package frame_pkg;

  localparam int D_WIDTH   = 8;
  localparam int A_WIDTH   = 21;
  localparam int MASKLEN   = 392;
  localparam int FRAME_LEN = 921600;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a pop on empty is ignored and
// a push on full is taken only alongside a pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/dram_frame_reader.sv
// Walks one frame out of the byte-wide DRAM and streams it downstream,
// issuing reads only when the output FIFO has room for their data.
module dram_frame_reader #(
  parameter int D_WIDTH    = frame_pkg::D_WIDTH,
  parameter int A_WIDTH    = frame_pkg::A_WIDTH,
  parameter int MASKLEN    = frame_pkg::MASKLEN,
  parameter int FRAME_LEN  = frame_pkg::FRAME_LEN,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [A_WIDTH-1:0] base_addr,
  output logic               busy,
  output logic               done,
  output logic               mem_ren,
  output logic [A_WIDTH-1:0] mem_raddr,
  input  logic [MASKLEN-1:0] mem_rdata,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [D_WIDTH-1:0] pix_data,
  output logic               pix_last
);

  import frame_pkg::*;

  localparam int IW = A_WIDTH + 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IW-1:0] LEN  = IW'(FRAME_LEN);
  localparam logic [IW-1:0] LAST = IW'(FRAME_LEN - 1);

  state_t             state_q, state_d;
  logic [A_WIDTH-1:0] base_q, base_d;
  logic [A_WIDTH-1:0] raddr_q, raddr_d;
  logic [IW-1:0]      issue_q, issue_d;
  logic [IW-1:0]      out_q, out_d;
  logic               ren_q, ren_d;
  logic               pend_q;

  logic [CW-1:0]      fcount;
  logic               fempty, ffull;
  logic [D_WIDTH-1:0] fdata;
  logic               pop, credit;
  logic [1:0]         unused_bits;

  // Reads in flight still need a slot, so they count against capacity.
  assign credit = (32'(fcount) + 32'(ren_q) + 32'(pend_q))
                  < 32'(FIFO_DEPTH);

  assign pop       = !fempty && pix_ready;
  assign pix_valid = !fempty;
  assign pix_data  = fempty ? '0 : fdata;
  assign pix_last  = !fempty && (out_q == LAST);
  assign done      = pop && pix_last;
  assign busy      = (state_q != ST_IDLE);
  assign mem_ren   = ren_q;
  assign mem_raddr = raddr_q;

  assign unused_bits = {ffull, ^mem_rdata[MASKLEN-1:D_WIDTH]};

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    raddr_d = raddr_q;
    issue_d = issue_q;
    out_d   = out_q;
    ren_d   = 1'b0;
    if (pop) out_d = out_q + 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          base_d  = base_addr;
          raddr_d = base_addr;
          issue_d = IW'(1);
          out_d   = '0;
          ren_d   = 1'b1;
        end
      end
      ST_RUN: begin
        if (issue_q == LEN) begin
          state_d = ST_DRAIN;
        end else if (credit) begin
          ren_d   = 1'b1;
          raddr_d = base_q + issue_q[A_WIDTH-1:0];
          issue_d = issue_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      raddr_q <= '0;
      issue_q <= '0;
      out_q   <= '0;
      ren_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      raddr_q <= raddr_d;
      issue_q <= issue_d;
      out_q   <= out_d;
      ren_q   <= ren_d;
      pend_q  <= ren_q;
    end
  end

  sync_fifo #(
    .WIDTH (D_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (pend_q),
    .pop_i   (pop),
    .wdata_i (mem_rdata[D_WIDTH-1:0]),
    .rdata_o (fdata),
    .count_o (fcount),
    .empty_o (fempty),
    .full_o  (ffull)
  );

endmodule
